// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch and decode stages:
//   - fetch_state_t : fetch FSM encodings (exposed on o_state for debug)
//   - HALT_ENCODING : instruction word that stops the fetch unit
//   - NOP_INSTR     : bubble inserted on flush / after halt
//   - BYTES_PER_WORD: program bytes per instruction word during load
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] HALT_ENCODING  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
// Word-wide instruction store: one synchronous write port, one asynchronous
// (combinational) read port. Contents are not affected by any reset.
// Ports:
//   clk    : write clock
//   wr_en  : write strobe
//   waddr  : write word address
//   wdata  : write data
//   raddr  : read word address
//   rdata  : read data (combinational)
// ---------------------------------------------------------------------------
module instruction_memory #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [NB_MEM_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0]     wdata,
  input  logic [NB_MEM_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0]     rdata
);

  localparam int DEPTH = 1 << NB_MEM_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Pipeline fetch stage with a byte-serial program loader. In LOAD the
// incoming bytes are packed MSB-first into words and written sequentially
// into the instruction memory. In RUN each advance cycle registers the
// addressed word and PC+4 into the IF/ID register and moves the PC
// (sequential or jump). Fetching the halt word freezes the PC and parks the
// FSM in HALTED until a new program load is requested.
// Ports:
//   clk           : clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_load_en     : program-load mode request
//   i_load_valid  : load byte strobe
//   i_load_byte   : program byte
//   i_run         : start-execution pulse
//   i_en          : fetch advance enable
//   i_stall       : hold PC and IF/ID register
//   i_flush       : replace next IF/ID instruction with NOP
//   i_jump        : redirect request
//   i_jump_addr   : redirect target byte address
//   o_instruction : IF/ID instruction
//   o_pcounter4   : IF/ID PC+4
//   o_pcounter    : current PC
//   o_halt        : halt word fetched
//   o_state       : FSM state (debug)
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  NB_DATA     = 32,
  parameter int                  NB_MEM_ADDR = 8,
  parameter logic [NB_DATA-1:0]  HALT_WORD   = NB_DATA'(HALT_ENCODING)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_load_en,
  input  logic               i_load_valid,
  input  logic [7:0]         i_load_byte,
  input  logic               i_run,
  input  logic               i_en,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pcounter,
  output logic               o_halt,
  output logic [1:0]         o_state
);

  localparam logic [NB_DATA-1:0] NOP_WORD      = NB_DATA'(NOP_INSTR);
  localparam logic [1:0]         LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

  fetch_state_t state_reg, state_next;

  logic [NB_DATA-1:0]     pc_reg, pc_next;
  logic [NB_DATA-1:0]     instr_reg, instr_next;
  logic [NB_DATA-1:0]     pc4_reg, pc4_next;
  logic                   halt_reg, halt_next;
  logic [NB_MEM_ADDR-1:0] waddr_reg, waddr_next;
  logic [1:0]             byte_cnt_reg, byte_cnt_next;
  logic [NB_DATA-1:0]     asm_reg, asm_next;

  logic                   mem_we;
  logic [NB_DATA-1:0]     mem_rdata;
  logic [NB_DATA-1:0]     asm_shifted;
  logic [NB_DATA-1:0]     pc_plus4;
  logic [NB_DATA-1:0]     pc_redirect;
  logic                   advance;

  // Bytes enter at the bottom and shift up, so the first byte of a word
  // ends up in the most significant position after four strobes.
  assign asm_shifted = {asm_reg[NB_DATA-9:0], i_load_byte};
  assign pc_plus4    = pc_reg + NB_DATA'(4);
  assign pc_redirect = i_jump ? i_jump_addr : pc_plus4;
  // Stall outranks everything except reset; a held cycle ignores jump/flush.
  assign advance     = i_en && !i_stall;

  instruction_memory #(
    .NB_DATA     (NB_DATA),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) u_imem (
    .clk   (clk),
    .wr_en (mem_we),
    .waddr (waddr_reg),
    .wdata (asm_shifted),
    .raddr (pc_reg[NB_MEM_ADDR+1:2]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_reg       <= '0;
      instr_reg    <= '0;
      pc4_reg      <= '0;
      halt_reg     <= 1'b0;
      waddr_reg    <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
    end else begin
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      pc4_reg      <= pc4_next;
      halt_reg     <= halt_next;
      waddr_reg    <= waddr_next;
      byte_cnt_reg <= byte_cnt_next;
      asm_reg      <= asm_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    pc4_next      = pc4_reg;
    halt_next     = halt_reg;
    waddr_next    = waddr_reg;
    byte_cnt_next = byte_cnt_reg;
    asm_next      = asm_reg;
    mem_we        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_load_en) begin
          state_next    = ST_LOAD;
          pc_next       = '0;
          waddr_next    = '0;
          byte_cnt_next = '0;
          asm_next      = '0;
        end else if (i_run) begin
          state_next = ST_RUN;
        end
      end

      ST_LOAD: begin
        if (!i_load_en) begin
          // Leaving load mode drops any partially assembled word.
          state_next    = ST_IDLE;
          byte_cnt_next = '0;
          asm_next      = '0;
        end else if (i_load_valid) begin
          asm_next = asm_shifted;
          if (byte_cnt_reg == LAST_BYTE_IDX) begin
            mem_we        = 1'b1;
            waddr_next    = waddr_reg + 1'b1;
            byte_cnt_next = '0;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (advance) begin
          pc4_next = pc_plus4;
          if (i_flush) begin
            instr_next = NOP_WORD;
            pc_next    = pc_redirect;
          end else if (mem_rdata == HALT_WORD) begin
            // Halt wins over a simultaneous jump: PC is frozen here.
            instr_next = mem_rdata;
            halt_next  = 1'b1;
            state_next = ST_HALTED;
          end else begin
            instr_next = mem_rdata;
            pc_next    = pc_redirect;
          end
        end
      end

      ST_HALTED: begin
        if (i_load_en) begin
          state_next    = ST_LOAD;
          halt_next     = 1'b0;
          pc_next       = '0;
          waddr_next    = '0;
          byte_cnt_next = '0;
          asm_next      = '0;
        end else if (advance) begin
          instr_next = NOP_WORD;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_instruction = instr_reg;
  assign o_pcounter4   = pc4_reg;
  assign o_pcounter    = pc_reg;
  assign o_halt        = halt_reg;
  assign o_state       = state_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the fetch unit kept in this file.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int          DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_load_en;
  logic        i_load_valid;
  logic [7:0]  i_load_byte;
  logic        i_run;
  logic        i_en;
  logic        i_stall;
  logic        i_flush;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic [31:0] o_instruction;
  logic [31:0] o_pcounter4;
  logic [31:0] o_pcounter;
  logic        o_halt;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  instruction_fetch #(
    .NB_DATA     (32),
    .NB_MEM_ADDR (8),
    .HALT_WORD   (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_load_en     (i_load_en),
    .i_load_valid  (i_load_valid),
    .i_load_byte   (i_load_byte),
    .i_run         (i_run),
    .i_en          (i_en),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_pcounter    (o_pcounter),
    .o_halt        (o_halt),
    .o_state       (o_state)
  );

  int total = 0;
  int bad   = 0;

  // Model state: 0 idle, 1 load, 2 run, 3 halted
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_halt;
  int          m_state;
  int          m_waddr;
  logic [7:0]  m_bytes [$];

  logic [31:0] n_pc, n_instr, n_pc4;
  logic        n_halt;
  int          n_state;
  int          n_waddr;

  logic [31:0] prog [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0;
    m_state = 0; m_waddr = 0;
    m_bytes.delete();
  endtask

  // Next-cycle outcome derived from the behavioural rules and current inputs.
  task automatic model_step();
    logic [31:0] word;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_halt = m_halt;
    n_state = m_state; n_waddr = m_waddr;
    if (!i_rst_n) begin
      n_pc = 0; n_instr = 0; n_pc4 = 0; n_halt = 0; n_state = 0; n_waddr = 0;
      m_bytes.delete();
    end else begin
      case (m_state)
        0: begin
          if (i_load_en) begin
            n_state = 1; n_pc = 0; n_waddr = 0; m_bytes.delete();
          end else if (i_run) begin
            n_state = 2;
          end
        end
        1: begin
          if (!i_load_en) begin
            n_state = 0; m_bytes.delete();
          end else if (i_load_valid) begin
            m_bytes.push_back(i_load_byte);
            if (m_bytes.size() == 4) begin
              m_mem[m_waddr] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
              n_waddr = (m_waddr + 1) % DEPTH;
              m_bytes.delete();
            end
          end
        end
        2: begin
          if (i_en && !i_stall) begin
            word  = m_mem[(m_pc >> 2) % DEPTH];
            n_pc4 = m_pc + 32'd4;
            if (i_flush) begin
              n_instr = 0;
              n_pc    = i_jump ? i_jump_addr : m_pc + 32'd4;
            end else if (word == HALT) begin
              n_instr = word; n_halt = 1; n_state = 3;
            end else begin
              n_instr = word;
              n_pc    = i_jump ? i_jump_addr : m_pc + 32'd4;
            end
          end
        end
        default: begin
          if (i_load_en) begin
            n_state = 1; n_halt = 0; n_pc = 0; n_waddr = 0; m_bytes.delete();
          end else if (i_en && !i_stall) begin
            n_instr = 0;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("cyc_instr", o_instruction, m_instr);
    check("cyc_pc4",   o_pcounter4,   m_pc4);
    check("cyc_pc",    o_pcounter,    m_pc);
    check("cyc_halt",  32'(o_halt),   32'(m_halt));
    check("cyc_state", 32'(o_state),  32'(m_state));
  endtask

  // One clock: predict, let the edge happen, commit, compare at negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_halt = n_halt;
    m_state = n_state; m_waddr = n_waddr;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    i_load_en = 0; i_load_valid = 0; i_load_byte = 0; i_run = 0;
    i_en = 0; i_stall = 0; i_flush = 0; i_jump = 0; i_jump_addr = 0;
  endtask

  task automatic load_words(input int n);
    i_en = 0; i_run = 0;
    i_load_en = 1; i_load_valid = 0;
    tick();
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) begin
          i_load_valid = 0;
          tick();
        end
        i_load_valid = 1;
        i_load_byte  = prog[w][31-8*b -: 8];
        tick();
      end
    end
    i_load_valid = 0; i_load_en = 0;
    tick();
  endtask

  task automatic start_run();
    i_run = 1;
    tick();
    i_run = 0;
  endtask

  // From HALTED: stray run pulse, load-mode bounce, then restart at PC 0.
  task automatic recover();
    i_en = 0; i_stall = 0; i_flush = 0; i_jump = 0;
    i_run = 1; tick(); i_run = 0;
    i_load_en = 1; tick(); i_load_en = 0; tick();
    start_run();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    i_rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    i_rst_n = 1;

    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = $urandom;
      if (prog[i] == HALT) prog[i] = 32'h1234_5678;
    end
    prog[0]   = 32'h2001_0005;
    prog[1]   = HALT;
    prog[200] = HALT;

    // Load then fetch
    load_words(DEPTH);
    start_run();
    i_en = 1;
    tick();
    check("lf_instr", o_instruction, 32'h2001_0005);
    check("lf_pc4",   o_pcounter4,   32'd4);
    tick();
    check("lf_halt",  32'(o_halt),  32'd1);
    check("lf_state", 32'(o_state), 32'd3);
    check("lf_pc",    o_pcounter,   32'd4);
    tick();
    check("halted_nop", o_instruction, 32'd0);
    i_run = 1; tick(); i_run = 0;
    check("halted_run_ignored", 32'(o_state), 32'd3);

    // Replace the early halt, keep the rest of memory
    prog[1] = 32'h0BAD_F00D;
    load_words(2);

    // Partial load: three bytes then leave load mode
    i_load_en = 1; tick();
    for (int b = 0; b < 3; b++) begin
      i_load_valid = 1; i_load_byte = 8'hAA; tick();
    end
    i_load_valid = 0; i_load_en = 0; tick();
    start_run();
    i_en = 1;
    tick();
    check("partial_mem0", o_instruction, 32'h2001_0005);
    tick();
    check("pc8", o_pcounter, 32'd8);

    // Stall hold
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc",    o_pcounter,    32'd8);
      check("stall_instr", o_instruction, 32'h0BAD_F00D);
      check("stall_pc4",   o_pcounter4,   32'd8);
    end
    i_stall = 0;
    tick();
    check("stall_release_pc", o_pcounter, 32'd12);

    // Stall vs jump
    i_stall = 1; i_jump = 1; i_jump_addr = 32'h80;
    tick();
    check("stall_jump_pc", o_pcounter, 32'd12);
    i_stall = 0; i_jump_addr = 32'h8;
    tick();
    check("jump_back_pc", o_pcounter, 32'd8);

    // Jump redirect with flush
    i_jump_addr = 32'h40; i_flush = 1;
    tick();
    check("flush_instr", o_instruction, 32'd0);
    check("flush_pc4",   o_pcounter4,   32'd12);
    check("jump_pc",     o_pcounter,    32'h40);
    i_flush = 0;

    // Wrap
    i_jump_addr = 32'h3FC;
    tick();
    check("wrap_pc_3fc", o_pcounter, 32'h3FC);
    i_jump = 0;
    tick();
    check("wrap_instr255", o_instruction, prog[255]);
    check("wrap_pc_400",   o_pcounter,    32'h400);
    tick();
    check("wrap_instr0", o_instruction, 32'h2001_0005);
    check("wrap_pc4",    o_pcounter4,   32'h404);

    // Randomized run
    for (int c = 0; c < 800; c++) begin
      if (m_state == 3) begin
        recover();
      end else begin
        i_en    = ($urandom_range(3) != 0);
        i_stall = ($urandom_range(3) == 0);
        i_flush = ($urandom_range(5) == 0);
        i_jump  = ($urandom_range(4) == 0);
        case ($urandom_range(3))
          0:       i_jump_addr = 32'h320;
          1:       i_jump_addr = $urandom;
          default: i_jump_addr = 32'($urandom_range(255)) << 2;
        endcase
        tick();
      end
    end
    if (m_state == 3) recover();

    // Async reset mid-RUN
    i_en = 1; i_stall = 0; i_flush = 0; i_jump = 1; i_jump_addr = 32'h20;
    tick();
    i_jump = 0; i_en = 0;
    check("pre_reset_pc", o_pcounter, 32'h20);
    i_rst_n = 0;
    #1;
    model_reset();
    check("areset_instr", o_instruction,   32'd0);
    check("areset_pc4",   o_pcounter4,     32'd0);
    check("areset_pc",    o_pcounter,      32'd0);
    check("areset_halt",  32'(o_halt),     32'd0);
    check("areset_state", 32'(o_state),    32'd0);
    tick();
    i_rst_n = 1;
    i_en = 1;
    tick();
    check("post_reset_idle", 32'(o_state), 32'd0);
    start_run();
    tick();
    check("mem_intact", o_instruction, 32'h2001_0005);
    tick();
    check("mem_intact1", o_instruction, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
